digit_scanner: RTL
==================

# digit_scanner

- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- A free-running prescaler steps a digit index through all digits. For each step it presents the addressed digit's code on `selected_value` and the matching active-low anode enable, with a configurable dead time between digits to suppress ghosting.
- Display data is double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new data.
- Sits between the value-producing datapath and the segment decoder; replaces the fixed 4-digit, 4-bit, combinational digit selector.

## Interface
- `DIGITS`, default 4: number of digits; minimum 2.
- `DIGIT_W`, default 4: bits per digit code.
- `PRESCALE`, default 50000: clock cycles per digit slot; must be greater than `DEAD_CYCLES`.
- `DEAD_CYCLES`, default 2: cycles at the start of each slot with all anodes off; 0 is legal.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `value` in DIGITS*DIGIT_W: digit codes, digit k = `value[k*DIGIT_W +: DIGIT_W]`.
- `load` in 1: capture `value` into the pending buffer.
- `enable` in 1: scan run; when low, the display is dark and scanning is frozen.
- `selected_value` out DIGIT_W: code of the current digit.
- `dig_sel` out max(1,$clog2(DIGITS)): current digit index.
- `anode_n` out DIGITS: active-low one-hot anode enables.
- `frame_done` out 1: one-cycle pulse at frame wrap.

## Operation
- Internal state:
  - Prescaler `p`, range 0..PRESCALE-1.
  - Digit index `d`, range 0..DIGITS-1.
  - Pending buffer, with a `pend_v` flag.
  - Shadow buffer.
- Reset values:
  - `p`, `d`, pending, `pend_v`, shadow: all 0.
  - `selected_value`: 0.
  - `dig_sel`: 0.
  - `anode_n`: all ones.
  - `frame_done`: 0.
- Prescaler:
  - With `enable`=1, `p` increments each cycle and wraps PRESCALE-1 -> 0.
  - `d` advances on that wrap.
  - `d` wraps DIGITS-1 -> 0; this is the frame wrap.
  - With `enable`=0, `p` and `d` hold.
- Load:
  - `load`=1 writes `value` into pending and sets `pend_v`.
  - A second load before commit overwrites pending; the last one wins.
- Commit at frame wrap: if `pend_v`, copy pending into shadow and clear `pend_v`.
- Load coinciding with frame wrap: `value` goes directly into shadow, and `pend_v` is cleared.
- Commit while disabled: with `enable`=0, a load commits to shadow immediately, because no frame is being shown.
- Anodes:
  - `anode_n[d]`=0 iff `enable`=1 and `p` >= DEAD_CYCLES.
  - All other bits are 1.
  - Never more than one bit is low.
- Outputs: `selected_value` = shadow digit `d`; `dig_sel` = `d`.
- Frame pulse: `frame_done`=1 for exactly one cycle, when `d` transitions DIGITS-1 -> 0.
- Reset mid-slot or mid-frame discards pending and shadow and returns everything to reset values.

## Timing
- All outputs are registered and reflect the internal state after the same clock edge. `dig_sel`, `selected_value`, `anode_n` and `frame_done` are therefore mutually consistent every cycle.
- Slot timeline:
  - A slot lasts PRESCALE cycles.
  - Anodes stay dark for the first DEAD_CYCLES cycles of the slot, including the cycle in which `dig_sel` changes.
  - The lit window is PRESCALE-DEAD_CYCLES cycles.
- Frame period: DIGITS*PRESCALE cycles.
- Load-to-display latency:
  - From a `load` sample to a visible change, the minimum is 1 cycle (coinciding with frame wrap, or while disabled).
  - The maximum is DIGITS*PRESCALE cycles.
- `enable` falling: `anode_n` is all ones on the next cycle; `p` and `d` freeze.
- `enable` rising: scanning resumes from the frozen `p` and `d`.

## Configuration
- Macro: `DIGIT_SCAN_BLANK_EN`.
- Defined: leading-zero blanking.
  - Digit k (k >= 1) is blanked (its anode stays high) when its shadow code is 0 and every shadow digit above k is also 0.
  - Digit 0 is never blanked.
  - Blanking is evaluated from shadow, so it changes only at commit.
- Undefined: no blanking logic is present; all digits light whenever the rules above allow.

## Test plan
All scenarios use DIGITS=4, DIGIT_W=4, PRESCALE=8, DEAD_CYCLES=2.
- Reset:
  - Stimulus: hold `reset` 3 cycles, then `enable`=1.
  - Required response: first cycles show `dig_sel`=0, `selected_value`=0, `anode_n`=4'b1111; `anode_n`=4'b1110 from cycle 2 of the slot.
  - Required response: `dig_sel`=1 after 8 cycles.
- Full scan:
  - Stimulus: load `value`=16'h4321 while disabled, then enable.
  - Required response: `dig_sel`/`selected_value` sequence 0/1, 1/2, 2/3, 3/4, 8 cycles each.
  - Required response: `frame_done` single pulse every 32 cycles.
  - Required response: each slot has 2 dark cycles, then 6 lit cycles.
- Tearing guard:
  - Stimulus: mid-frame, load 16'hABCD while showing 16'h4321.
  - Required response: the remaining digits of the frame still show 4321 data.
  - Required response: the next frame shows D, C, B, A.
- Wrap race:
  - Stimulus: load 16'h1111 on the frame-wrap cycle.
  - Required response: digit 0 of the new frame shows 1; `pend_v` is clear.
- Disable and reset mid-slot:
  - Stimulus: drop `enable` at `p`=4.
  - Required response: `anode_n`=4'b1111 next cycle; on re-enable the slot finishes after 4 more cycles.
  - Stimulus: assert `reset` mid-slot.
  - Required response: all reset values are restored.
- Blanking, with `DIGIT_SCAN_BLANK_EN` defined:
  - Stimulus: `value`=16'h0050.
  - Required response: digits 2 and 3 stay dark; digits 1 and 0 light.
  - Stimulus: `value`=16'h0000.
  - Required response: only digit 0 lights.

Source files
------------

// File: rtl/digit_scanner_if.sv
// digit_scanner_if: bus between the value-producing datapath and the digit scanner
//   value/load/enable    : digit codes, capture strobe and scan run, driven by the datapath (master)
//   selected_value       : code of the digit currently shown
//   dig_sel              : index of the digit currently shown
//   anode_n              : active-low one-hot anode enables
//   frame_done           : one-cycle pulse at frame wrap
interface digit_scanner_if #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4
);
   localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   logic [DIGITS*DIGIT_W-1:0] value;
   logic                      load;
   logic                      enable;
   logic [DIGIT_W-1:0]        selected_value;
   logic [SW-1:0]             dig_sel;
   logic [DIGITS-1:0]         anode_n;
   logic                      frame_done;
   modport master (output value, load, enable, input selected_value, dig_sel, anode_n, frame_done);
   modport slave  (input value, load, enable, output selected_value, dig_sel, anode_n, frame_done);
endinterface

// File: rtl/digit_scanner.sv
// digit_scanner: time-multiplexed common-anode seven-segment driver with frame-aligned double buffering
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : digit_scanner_if.slave (value/load/enable in; selected_value/dig_sel/anode_n/frame_done out)
//   Optional leading-zero blanking is compiled in when DIGIT_SCAN_BLANK_EN is defined.
module digit_scanner #(
   parameter int DIGITS      = 4,
   parameter int DIGIT_W     = 4,
   parameter int PRESCALE    = 50000,
   parameter int DEAD_CYCLES = 2
) (
   input logic            clk,
   input logic            reset,
   digit_scanner_if.slave bus
);
   localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam int W  = DIGITS * DIGIT_W;
   logic [PW-1:0]      p_q, p_d;
   logic [SW-1:0]      d_q, d_d;
   logic [W-1:0]       pend_q, pend_d, shadow_q, shadow_d;
   logic               pend_v_q, pend_v_d;
   logic [DIGIT_W-1:0] sel_q, sel_d;
   logic [DIGITS-1:0]  an_q, an_d, lit;
   logic               fd_q, p_wrap, f_wrap;
`ifdef DIGIT_SCAN_BLANK_EN
   logic               z;
`endif
   // Outputs are computed from next-state so they line up with p/d after the same edge.
   always_comb begin
      p_wrap   = bus.enable && p_q == PW'(PRESCALE - 1);
      f_wrap   = p_wrap && d_q == SW'(DIGITS - 1);
      p_d      = !bus.enable ? p_q : p_wrap ? '0 : p_q + 1'b1;
      d_d      = !p_wrap ? d_q : f_wrap ? '0 : d_q + 1'b1;
      pend_d   = bus.load ? bus.value : pend_q;
      // A load at frame wrap or while dark bypasses pending and lands in shadow at once.
      pend_v_d = bus.load ? bus.enable && !f_wrap : pend_v_q && !f_wrap;
      shadow_d = (bus.load && (!bus.enable || f_wrap)) ? bus.value :
                 (f_wrap && pend_v_q) ? pend_q : shadow_q;
      sel_d    = shadow_d[d_d*DIGIT_W +: DIGIT_W];
      lit      = '1;
`ifdef DIGIT_SCAN_BLANK_EN
      // z stays set while every digit from the top down to k is zero.
      z = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         z      = z && shadow_d[k*DIGIT_W +: DIGIT_W] == '0;
         lit[k] = !z;
      end
`endif
      an_d = '1;
      if (bus.enable && 32'(p_d) >= DEAD_CYCLES && lit[d_d]) an_d[d_d] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         p_q      <= '0;
         d_q      <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         shadow_q <= '0;
         sel_q    <= '0;
         an_q     <= '1;
         fd_q     <= 1'b0;
      end else begin
         p_q      <= p_d;
         d_q      <= d_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         shadow_q <= shadow_d;
         sel_q    <= sel_d;
         an_q     <= an_d;
         fd_q     <= f_wrap;
      end
   end
   assign bus.selected_value = sel_q;
   assign bus.dig_sel        = d_q;
   assign bus.anode_n        = an_q;
   assign bus.frame_done     = fd_q;
endmodule
